param_delay_pipe: RTL and testbench
===================================

Name: param_delay_pipe

Overview:
- Parametrised successor of the fixed register-delay cell (q <= #(REG_DELAY*2) d). Delays a multi-lane data word plus a valid flag by a run-time selectable number of clock cycles, 0..MAX_DELAY.
- Adds enable/stall, flush, optional per-lane bit reversal on output, and a sticky configuration-error flag.
- Used as a retiming/alignment stage between datapath blocks with mismatched latency.

Parameters:
- WIDTH, 8, bits per lane.
- LANES, 4, number of independent data lanes sharing one valid and one delay setting.
- MAX_DELAY, 8, maximum delay in cycles (>=1); number of storage stages.
- SEL_W, 4, width of dly_sel; must satisfy 2**SEL_W > MAX_DELAY.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- en  input  1  pipeline advance enable; low = stall (all state frozen).
- flush  input  1  synchronous clear of all stage valid bits.
- dly_sel  input  SEL_W  requested delay in cycles.
- rev  input  1  when high, each lane is bit-reversed on output (bit i -> bit WIDTH-1-i).
- d  input  LANES*WIDTH  input data; lane k = d[k*WIDTH +: WIDTH].
- d_valid  input  1  input qualifier.
- q  output  LANES*WIDTH  delayed (optionally reversed) data.
- q_valid  output  1  output qualifier.
- cfg_err  output  1  sticky: dly_sel exceeded MAX_DELAY.

Behaviour:
- Storage: MAX_DELAY stages, each holding LANES*WIDTH data bits plus 1 valid bit. Stage 0 loads d/d_valid; stage i loads stage i-1. Shifting occurs only on cycles where en=1.
- Effective delay L = min(dly_sel, MAX_DELAY).
  - If dly_sel > MAX_DELAY on a clock edge, cfg_err is set to 1.
  - cfg_err clears only on reset.
- L=0 (bypass): q = d and q_valid = d_valid, combinationally. en and the stage contents have no effect on q/q_valid.
- L>=1: q/q_valid are taken from stage L-1, giving exactly L enabled cycles of latency. q is mux of flop outputs only; no extra register.
- Stall (en=0): no stage loads; q/q_valid hold their value. Stage valid bits are not cleared.
- flush=1 at an edge: all stage valid bits are cleared; data bits are don't-care.
  - Applies regardless of en.
  - flush has priority over the shift: the input on that cycle is discarded.
- Delay change:
  - At any edge where the registered previous L differs from the current L, all stage valid bits are cleared (same effect as flush), preventing duplicated or skipped words.
  - After the change, q_valid stays 0 until new data has traversed L stages.
  - The previous-L register updates every cycle, independent of en.
- rev: applied only at the output mux, combinationally. Changing rev never affects stored data or valid.
- Reset (async assert, sync deassert handled upstream):
  - All stage valid bits = 0, stage data = 0, previous-L register = 0, cfg_err = 0.
  - q = 0 and q_valid = 0 for L>=1; in bypass (L=0), q/q_valid follow d/d_valid.
  - Reset asserted mid-stream discards all in-flight words.
- Simultaneous events:
  - flush + delay change: single clear.
  - en=0 + flush: clear still occurs.
  - d_valid=0 words propagate as bubbles, with data still shifted.

Test Plan:
- Basic delay: reset, dly_sel=3, en=1, LANES=4/WIDTH=8, drive d=32'h04030201 valid for 1 cycle -> q=32'h04030201 with q_valid=1 exactly 3 cycles later; q_valid=0 on all other cycles.
- Bypass and max: dly_sel=0, d=32'hA5A5A5A5 valid -> q identical same cycle. Then dly_sel=8, stream 1..20 -> output 1..20 in order, each 8 cycles late. Then dly_sel=9 -> L saturates to 8 and cfg_err=1 until reset.
- Stall: dly_sel=4, stream 1..10, hold en=0 for 3 cycles mid-stream -> output order 1..10 unbroken, q/q_valid frozen during the stall, total latency 4+3 cycles for the words in flight.
- Flush/delay change: stream with dly_sel=5, assert flush for 1 cycle -> q_valid=0 for the next 5 cycles, then post-flush words appear. Change dly_sel 5->2 mid-stream -> no word emitted twice, q_valid=0 for 2 cycles after the change.
- Reverse: dly_sel=1, d lane0=8'b0000_0001, rev=1 -> q lane0=8'b1000_0000 one cycle later. Toggle rev while the word is held in stall -> q flips immediately.
- Async reset mid-stream: assert reset_n=0 between edges while data is in flight -> q_valid=0 and q=0 immediately. After release with dly_sel=3, no stale words appear.

Source files
------------

// File: rtl/param_delay_pipe_if.sv
// Bundles the datapath/control signals of param_delay_pipe.
// The master drives the request side; the slave (the pipe) drives the results.
interface param_delay_pipe_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LANES = 4,
  parameter int unsigned SEL_W = 4
);
  logic                   en;
  logic                   flush;
  logic [SEL_W-1:0]       dly_sel;
  logic                   rev;
  logic [LANES*WIDTH-1:0] d;
  logic                   d_valid;
  logic [LANES*WIDTH-1:0] q;
  logic                   q_valid;
  logic                   cfg_err;

  modport master (
    output en, flush, dly_sel, rev, d, d_valid,
    input  q, q_valid, cfg_err
  );

  modport slave (
    input  en, flush, dly_sel, rev, d, d_valid,
    output q, q_valid, cfg_err
  );
endinterface

// File: rtl/param_delay_pipe.sv
// Run-time selectable delay line (0..MAX_DELAY cycles) for a multi-lane word plus valid.
// Supports stall, flush, output bit reversal per lane and a sticky config-error flag.
module param_delay_pipe #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned LANES     = 4,
  parameter int unsigned MAX_DELAY = 8,
  parameter int unsigned SEL_W     = 4
) (
  input logic              clk,
  input logic              reset_n,
  param_delay_pipe_if.slave bus
);

  localparam int unsigned DW = LANES * WIDTH;

  logic [DW-1:0]        data_q [MAX_DELAY];
  logic [MAX_DELAY-1:0] valid_q;
  logic [SEL_W-1:0]     prev_l_q;
  logic                 cfg_err_q;

  logic [SEL_W-1:0]     cur_l;
  logic                 over_max;
  logic                 clear;
  logic [DW-1:0]        raw_data;
  logic                 raw_valid;

  // Saturate the requested delay and detect any change of effective delay.
  always_comb begin
    over_max = (bus.dly_sel > SEL_W'(MAX_DELAY));
    cur_l    = over_max ? SEL_W'(MAX_DELAY) : bus.dly_sel;
    // A delay change invalidates in-flight words so none is duplicated or skipped.
    clear    = bus.flush || (cur_l != prev_l_q);
  end

  // Previous-delay tracker and sticky error flag; both update regardless of en.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_l_q  <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      prev_l_q <= cur_l;
      if (over_max) begin
        cfg_err_q <= 1'b1;
      end
    end
  end

  // Storage stages: clear beats shift; clear applies even while stalled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(MAX_DELAY); i++) begin
        data_q[i] <= '0;
      end
      valid_q <= '0;
    end else if (clear) begin
      valid_q <= '0;
    end else if (bus.en) begin
      data_q[0]  <= bus.d;
      valid_q[0] <= bus.d_valid;
      for (int i = 1; i < int'(MAX_DELAY); i++) begin
        data_q[i]  <= data_q[i-1];
        valid_q[i] <= valid_q[i-1];
      end
    end
  end

  // Output select: bypass at L=0, otherwise stage L-1 (flop outputs only).
  always_comb begin
    raw_data  = bus.d;
    raw_valid = bus.d_valid;
    for (int i = 0; i < int'(MAX_DELAY); i++) begin
      if (cur_l == SEL_W'(i + 1)) begin
        raw_data  = data_q[i];
        raw_valid = valid_q[i];
      end
    end
  end

  // Per-lane bit reversal happens only here, so stored data is never affected.
  always_comb begin
    bus.q = '0;
    for (int k = 0; k < int'(LANES); k++) begin
      for (int b = 0; b < int'(WIDTH); b++) begin
        bus.q[k*WIDTH + b] = bus.rev ? raw_data[k*WIDTH + WIDTH - 1 - b]
                                     : raw_data[k*WIDTH + b];
      end
    end
    bus.q_valid = raw_valid;
    bus.cfg_err = cfg_err_q;
  end

endmodule

// File: tb/tb_param_delay_pipe.sv
// Self-checking bench for param_delay_pipe: a history-queue model checked every
// negedge, plus directed scenarios with hand-computed literal expectations.
module tb_param_delay_pipe;

  localparam int unsigned WIDTH     = 8;
  localparam int unsigned LANES     = 4;
  localparam int unsigned MAX_DELAY = 8;
  localparam int unsigned SEL_W     = 4;

  typedef struct packed {
    logic [31:0] data;
    logic        valid;
  } entry_t;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

  param_delay_pipe_if #(.WIDTH(WIDTH), .LANES(LANES), .SEL_W(SEL_W)) bus ();

  param_delay_pipe #(
    .WIDTH(WIDTH), .LANES(LANES), .MAX_DELAY(MAX_DELAY), .SEL_W(SEL_W)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Model state: words accepted since the last clear, newest first.
  entry_t hist[$];
  int     m_prev_l;
  logic   m_cfg_err;

  function automatic int eff_l(input logic [SEL_W-1:0] sel);
    return (int'(sel) > int'(MAX_DELAY)) ? int'(MAX_DELAY) : int'(sel);
  endfunction

  function automatic logic [31:0] lane_rev(input logic [31:0] w);
    logic [31:0] r;
    for (int k = 0; k < 4; k++)
      for (int b = 0; b < 8; b++)
        r[k*8 + b] = w[k*8 + 7 - b];
    return r;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hist.delete();
      m_prev_l  = 0;
      m_cfg_err = 1'b0;
    end else begin
      int l;
      l = eff_l(bus.dly_sel);
      if (int'(bus.dly_sel) > int'(MAX_DELAY)) m_cfg_err = 1'b1;
      if (bus.flush || l != m_prev_l) begin
        hist.delete();
      end else if (bus.en) begin
        hist.push_front('{data: bus.d, valid: bus.d_valid});
        if (hist.size() > int'(MAX_DELAY)) void'(hist.pop_back());
      end
      m_prev_l = l;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    int          l;
    logic        ev;
    logic [31:0] ed;
    l  = eff_l(bus.dly_sel);
    ev = 1'b0;
    ed = '0;
    if (l == 0) begin
      ev = bus.d_valid;
      ed = bus.d;
    end else if (hist.size() >= l) begin
      ev = hist[l-1].valid;
      ed = hist[l-1].data;
    end
    if (bus.rev) ed = lane_rev(ed);
    checks++;
    if (bus.q_valid !== ev) begin
      errors++;
      $display("FAIL model_q_valid t=%0t got=%0b exp=%0b", $time, bus.q_valid, ev);
    end
    if (ev) begin
      checks++;
      if (bus.q !== ed) begin
        errors++;
        $display("FAIL model_q t=%0t got=%h exp=%h", $time, bus.q, ed);
      end
    end
    checks++;
    if (bus.cfg_err !== m_cfg_err) begin
      errors++;
      $display("FAIL model_cfg_err t=%0t got=%0b exp=%0b", $time, bus.cfg_err, m_cfg_err);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%h exp=%h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] w);
    bus.d       = w;
    bus.d_valid = 1'b1;
    tick();
  endtask

  initial begin
    reset_n     = 1'b0;
    bus.en      = 1'b1;
    bus.flush   = 1'b0;
    bus.dly_sel = 4'd3;
    bus.rev     = 1'b0;
    bus.d       = '0;
    bus.d_valid = 1'b0;
    #1;
    chk("reset_q", bus.q, 32'h0);
    chk("reset_q_valid", 32'(bus.q_valid), 32'h0);
    chk("reset_cfg_err", 32'(bus.cfg_err), 32'h0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();  // first edge sees previous-L 0 vs 3 and clears

    // Basic delay of 3
    push(32'h04030201);
    bus.d_valid = 1'b0;
    bus.d       = '0;
    tick();
    chk("basic_not_yet", 32'(bus.q_valid), 32'h0);
    tick();
    chk("basic_q", bus.q, 32'h04030201);
    chk("basic_q_valid", 32'(bus.q_valid), 32'h1);

    // Bypass
    bus.dly_sel = 4'd0;
    bus.d       = 32'hA5A5A5A5;
    bus.d_valid = 1'b1;
    #1;
    chk("bypass_q", bus.q, 32'hA5A5A5A5);
    chk("bypass_q_valid", 32'(bus.q_valid), 32'h1);
    tick();

    // Maximum delay, stream 1..20
    bus.dly_sel = 4'd8;
    bus.d_valid = 1'b0;
    tick();
    for (int i = 1; i <= 20; i++) begin
      push(32'(i));
      if (i == 8) begin
        chk("max_first_q", bus.q, 32'h1);
        chk("max_first_valid", 32'(bus.q_valid), 32'h1);
      end
    end
    bus.d_valid = 1'b0;
    repeat (10) tick();

    // Out-of-range select saturates and sets the sticky error
    bus.dly_sel = 4'd9;
    tick();
    chk("cfg_err_set", 32'(bus.cfg_err), 32'h1);
    for (int i = 0; i < 3; i++) push(32'h50 + 32'(i));
    bus.d_valid = 1'b0;
    repeat (10) tick();
    bus.dly_sel = 4'd2;
    tick();
    chk("cfg_err_sticky", 32'(bus.cfg_err), 32'h1);

    // Stall mid-stream
    bus.dly_sel = 4'd4;
    tick();
    for (int i = 1; i <= 10; i++) begin
      push(32'(i));
      if (i == 5) begin
        chk("stall_pre_q", bus.q, 32'h2);
        bus.en = 1'b0;
        for (int s = 0; s < 3; s++) begin
          push(32'h99);
          chk("stall_hold_q", bus.q, 32'h2);
          chk("stall_hold_valid", 32'(bus.q_valid), 32'h1);
        end
        bus.en = 1'b1;
      end
    end
    bus.d_valid = 1'b0;
    repeat (8) tick();

    // Flush
    bus.dly_sel = 4'd5;
    tick();
    for (int i = 0; i < 8; i++) push(32'd100 + 32'(i));
    bus.flush = 1'b1;
    push(32'd200);
    bus.flush = 1'b0;
    chk("flush_valid_0", 32'(bus.q_valid), 32'h0);
    for (int k = 1; k <= 4; k++) begin
      push(32'd200 + 32'(k));
      chk("flush_valid_gap", 32'(bus.q_valid), 32'h0);
    end
    push(32'd205);
    chk("flush_first_q", bus.q, 32'd201);
    chk("flush_first_valid", 32'(bus.q_valid), 32'h1);

    // Delay change 5 -> 2 mid-stream
    bus.dly_sel = 4'd2;
    push(32'd300);
    chk("chg_valid_0", 32'(bus.q_valid), 32'h0);
    push(32'd301);
    chk("chg_valid_1", 32'(bus.q_valid), 32'h0);
    push(32'd302);
    chk("chg_first_q", bus.q, 32'd301);
    chk("chg_first_valid", 32'(bus.q_valid), 32'h1);
    bus.d_valid = 1'b0;
    repeat (4) tick();

    // Reverse
    bus.dly_sel = 4'd1;
    tick();
    bus.rev = 1'b1;
    push(32'h00000001);
    chk("rev_q", bus.q, 32'h00000080);
    bus.en      = 1'b0;
    bus.d_valid = 1'b0;
    bus.rev     = 1'b0;
    #1;
    chk("rev_off_q", bus.q, 32'h00000001);
    bus.rev = 1'b1;
    #1;
    chk("rev_on_q", bus.q, 32'h00000080);
    tick();
    bus.en  = 1'b1;
    bus.rev = 1'b0;

    // Async reset mid-stream
    bus.dly_sel = 4'd3;
    tick();
    for (int i = 0; i < 5; i++) push(32'd500 + 32'(i));
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_q", bus.q, 32'h0);
    chk("arst_q_valid", 32'(bus.q_valid), 32'h0);
    chk("arst_cfg_err", 32'(bus.cfg_err), 32'h0);
    @(negedge clk);
    reset_n     = 1'b1;
    bus.d_valid = 1'b0;
    repeat (5) begin
      tick();
      chk("arst_no_stale", 32'(bus.q_valid), 32'h0);
    end
    for (int i = 0; i < 6; i++) push(32'd600 + 32'(i));
    chk("arst_new_q", bus.q, 32'd603);
    bus.d_valid = 1'b0;
    repeat (5) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
